// File: rtl/doa_sweep_ctrl.sv
// MUSIC spatial-spectrum sweep controller: steps azimuth, drives Calu_Angle, keeps the minimum-power angle.
// Optional per-point watchdog enabled by defining DOA_SWEEP_TIMEOUT_EN.
module doa_sweep_ctrl #(
  parameter int ANG_WIDTH      = 10,
  parameter int VAL_WIDTH      = 48,
  parameter int ANG_START      = 0,
  parameter int ANG_STOP       = 180,
  parameter int ANG_STEP       = 1,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        search_start,
  output logic                        search_busy,
  output logic                        search_done,
  output logic                        search_error,
  output logic [ANG_WIDTH-1:0]        doa_angle,
  output logic signed [VAL_WIDTH-1:0] doa_min_value,
  output logic                        calu_angle_start,
  output logic [ANG_WIDTH-1:0]        azimuth_angle,
  input  logic                        calu_angle_done,
  input  logic signed [VAL_WIDTH-1:0] calu_angle_value
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_EVAL, S_ADVANCE, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [ANG_WIDTH-1:0]        cur_angle;
  logic [ANG_WIDTH-1:0]        best_ang;
  logic signed [VAL_WIDTH-1:0] sample;
  logic signed [VAL_WIDTH-1:0] best_val;
  logic                        have_pt;
  logic [ANG_WIDTH:0]          next_angle;
  logic                        timeout_hit;

  if (ANG_STEP < 1 || ANG_START > ANG_STOP || ANG_STOP >= (1 << ANG_WIDTH) ||
      TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("doa_sweep_ctrl: illegal parameter combination");
  end

  // One extra bit so the step past ANG_STOP can never wrap back into range.
  assign next_angle    = {1'b0, cur_angle} + (ANG_WIDTH+1)'(ANG_STEP);
  assign azimuth_angle = cur_angle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (search_start) state_nxt = S_ISSUE;
      S_ISSUE:   if (!calu_angle_done) state_nxt = S_WAIT;
      S_WAIT: begin
        if (calu_angle_done)  state_nxt = S_EVAL;
        else if (timeout_hit) state_nxt = S_DONE;
      end
      S_EVAL:    state_nxt = S_ADVANCE;
      S_ADVANCE: state_nxt = (next_angle > (ANG_WIDTH+1)'(ANG_STOP)) ? S_DONE : S_ISSUE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      calu_angle_start <= 1'b0;
      search_busy      <= 1'b0;
      search_done      <= 1'b0;
      doa_angle        <= '0;
      doa_min_value    <= '0;
      cur_angle        <= '0;
      best_ang         <= '0;
      best_val         <= '0;
      sample           <= '0;
      have_pt          <= 1'b0;
    end else begin
      calu_angle_start <= (state == S_ISSUE) && !calu_angle_done;
      search_busy      <= (state_nxt != S_IDLE);
      search_done      <= (state_nxt == S_DONE);
      // Results are loaded on the way into DONE so they are valid alongside search_done.
      if (state_nxt == S_DONE) begin
        doa_angle     <= have_pt ? best_ang : '0;
        doa_min_value <= have_pt ? best_val : '0;
      end
      case (state)
        S_IDLE: begin
          if (search_start) begin
            cur_angle <= ANG_WIDTH'(ANG_START);
            have_pt   <= 1'b0;
          end
        end
        S_WAIT: if (calu_angle_done) sample <= calu_angle_value;
        S_EVAL: begin
          if (!have_pt || sample < best_val) begin
            best_val <= sample;
            best_ang <= cur_angle;
          end
          have_pt <= 1'b1;
        end
        S_ADVANCE: if (state_nxt == S_ISSUE) cur_angle <= next_angle[ANG_WIDTH-1:0];
        default: ;
      endcase
    end
  end

`ifdef DOA_SWEEP_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  assign timeout_hit  = (state == S_WAIT) && !calu_angle_done &&
                        (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign search_error = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      wait_cnt <= (state == S_WAIT) ? wait_cnt + 1'b1 : '0;
      if (state == S_IDLE && search_start) err_q <= 1'b0;
      else if (timeout_hit)                err_q <= 1'b1;
    end
  end
`else
  assign timeout_hit  = 1'b0;
  assign search_error = 1'b0;
`endif

endmodule

// File: tb/tb_doa_sweep_ctrl.sv
// Self-checking bench for doa_sweep_ctrl: randomized calculator responses checked against an argmin model.
module tb_doa_sweep_ctrl;
  localparam int AW = 10;
  localparam int VW = 48;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          sstart [2];
  logic          sbusy  [2];
  logic          sdone  [2];
  logic          serr   [2];
  logic          cstart [2];
  logic          cdone  [2];
  logic [AW-1:0] dang   [2];
  logic [AW-1:0] az     [2];
  logic signed [VW-1:0] dval [2];
  logic signed [VW-1:0] cval [2];

  doa_sweep_ctrl #(.ANG_WIDTH(AW), .VAL_WIDTH(VW), .ANG_START(0), .ANG_STOP(180),
                   .ANG_STEP(1), .TIMEOUT_CYCLES(64)) dut0 (
    .clk(clk), .rst_n(rst_n), .search_start(sstart[0]), .search_busy(sbusy[0]),
    .search_done(sdone[0]), .search_error(serr[0]), .doa_angle(dang[0]),
    .doa_min_value(dval[0]), .calu_angle_start(cstart[0]), .azimuth_angle(az[0]),
    .calu_angle_done(cdone[0]), .calu_angle_value(cval[0]));

  doa_sweep_ctrl #(.ANG_WIDTH(AW), .VAL_WIDTH(VW), .ANG_START(2), .ANG_STOP(11),
                   .ANG_STEP(4), .TIMEOUT_CYCLES(64)) dut1 (
    .clk(clk), .rst_n(rst_n), .search_start(sstart[1]), .search_busy(sbusy[1]),
    .search_done(sdone[1]), .search_error(serr[1]), .doa_angle(dang[1]),
    .doa_min_value(dval[1]), .calu_angle_start(cstart[1]), .azimuth_angle(az[1]),
    .calu_angle_done(cdone[1]), .calu_angle_value(cval[1]));

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int latency = 20;
  int hold = 1;
  int hang_angle = -1;
  bit lat_rand = 1'b0;
  logic signed [VW-1:0] tbl [1024];

  int nlog  [2];
  int ndone [2];
  int slog_ang [2][512];
  int slog_cyc [2][512];
  int done_cyc [2];
  logic [AW-1:0]        got_ang  [2];
  logic signed [VW-1:0] got_val  [2];
  logic                 got_err  [2];
  logic                 got_busy [2];

  task automatic chk(input string tag, input bit ok,
                     input logic signed [63:0] o, input logic signed [63:0] e);
    checks++;
    if (!ok) begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_env
    initial begin
      int a, l;
      bit ab;
      cdone[g] = 1'b0;
      cval[g]  = '0;
      forever begin
        @(negedge clk);
        if (rst_n && cstart[g]) begin
          a = int'(az[g]);
          if (nlog[g] < 512) begin
            slog_ang[g][nlog[g]] = a;
            slog_cyc[g][nlog[g]] = cyc;
          end
          nlog[g]++;
          if (a != hang_angle) begin
            l  = lat_rand ? int'($urandom_range(1, 8)) : latency;
            ab = 1'b0;
            for (int i = 0; i < l && !ab; i++) begin
              @(negedge clk);
              if (!rst_n) ab = 1'b1;
            end
            if (!ab) begin
              cdone[g] = 1'b1;
              cval[g]  = tbl[a];
              for (int i = 0; i < hold; i++) @(negedge clk);
              cdone[g] = 1'b0;
            end
          end
        end
      end
    end

    initial forever begin
      @(negedge clk);
      if (sdone[g]) begin
        ndone[g]++;
        got_ang[g]  = dang[g];
        got_val[g]  = dval[g];
        got_err[g]  = serr[g];
        got_busy[g] = sbusy[g];
        done_cyc[g] = cyc;
      end
    end
  end

  task automatic fill_vshape();
    for (int a = 0; a < 1024; a++) tbl[a] = VW'(((a > 37) ? a - 37 : 37 - a) * 100 + 5);
  endtask

  task automatic fill_const(input int v);
    for (int a = 0; a < 1024; a++) tbl[a] = VW'(v);
  endtask

  task automatic fill_rand(input bit narrow);
    for (int a = 0; a < 1024; a++) begin
      if (narrow) tbl[a] = VW'(int'($urandom_range(0, 40)) - 20);
      else        tbl[a] = VW'({$urandom, $urandom});
    end
  endtask

  task automatic sweep(input int g, input int s, input int e, input int step,
                       input bit repulse, input string tag);
    int exp_ang[$];
    int best_a, li;
    logic signed [VW-1:0] best_v;
    bit first, hung;
    first  = 1'b1;
    hung   = 1'b0;
    best_a = 0;
    best_v = '0;
    for (int a = s; a <= e; a += step) begin
      exp_ang.push_back(a);
      if (a == hang_angle) begin
        hung = 1'b1;
        break;
      end
      if (first || tbl[a] < best_v) begin
        best_v = tbl[a];
        best_a = a;
      end
      first = 1'b0;
    end

    nlog[g]  = 0;
    ndone[g] = 0;
    @(negedge clk); sstart[g] = 1'b1;
    @(negedge clk); sstart[g] = 1'b0;
    for (int c = 0; c < 60000 && ndone[g] == 0; c++) begin
      @(negedge clk);
      sstart[g] = repulse && sbusy[g] && (c % 29 == 0);
    end
    sstart[g] = 1'b0;

    chk({tag, "_done_seen"}, ndone[g] === 1, ndone[g], 1);
    chk({tag, "_doa_angle"}, got_ang[g] === AW'(best_a), got_ang[g], best_a);
    chk({tag, "_doa_min"}, got_val[g] === best_v, got_val[g], best_v);
    chk({tag, "_err_at_done"}, got_err[g] === hung, got_err[g], hung);
    chk({tag, "_busy_at_done"}, got_busy[g] === 1'b1, got_busy[g], 1);
    if (hung) begin
      li = (nlog[g] > 0) ? nlog[g] - 1 : 0;
      chk({tag, "_tmo_cycles"}, (done_cyc[g] - slog_cyc[g][li]) === 64,
          done_cyc[g] - slog_cyc[g][li], 64);
    end
    repeat (4) @(negedge clk);
    chk({tag, "_single_done"}, ndone[g] === 1, ndone[g], 1);
    chk({tag, "_busy_after"}, sbusy[g] === 1'b0, sbusy[g], 0);
    chk({tag, "_err_hold"}, serr[g] === hung, serr[g], hung);
    chk({tag, "_n_starts"}, nlog[g] === exp_ang.size(), nlog[g], exp_ang.size());
    for (int i = 0; i < exp_ang.size() && i < nlog[g] && i < 512; i++)
      chk({tag, "_start_ang"}, slog_ang[g][i] === exp_ang[i], slog_ang[g][i], exp_ang[i]);
  endtask

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6*AW+8-1:0] rctl;
    logic [AW+4-1:0]   actl;
    sstart[0] = 1'b0;
    sstart[1] = 1'b0;
    nlog[0] = 0;  nlog[1] = 0;
    ndone[0] = 0; ndone[1] = 0;
    fill_vshape();

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rctl = {sbusy[0], sdone[0], serr[0], cstart[0], sbusy[1], sdone[1], serr[1],
            cstart[1], az[0], az[1], dang[0], dang[1]};
    chk("reset_ctl", rctl === '0, rctl, 0);
    chk("reset_val0", dval[0] === '0, dval[0], 0);
    chk("reset_val1", dval[1] === '0, dval[1], 0);
    rst_n = 1'b1;

    latency = 20; hold = 1; lat_rand = 1'b0;
    fill_vshape();
    sweep(0, 0, 180, 1, 1'b0, "vshape");

    fill_const(1000);
    sweep(0, 0, 180, 1, 1'b0, "const");

    lat_rand = 1'b1;
    fill_rand(1'b0);
    sweep(0, 0, 180, 1, 1'b0, "rand_wide");
    sweep(1, 2, 11, 4, 1'b0, "step4_wide");
    fill_rand(1'b1);
    sweep(1, 2, 11, 4, 1'b0, "step4_ties");
    sweep(0, 0, 180, 1, 1'b0, "rand_ties");

    hold = 3;
    sweep(0, 0, 180, 1, 1'b1, "repulse_hold3");
    hold = 1;

    lat_rand = 1'b0;
    latency  = 20;
    fill_vshape();
    nlog[0]  = 0;
    ndone[0] = 0;
    @(negedge clk); sstart[0] = 1'b1;
    @(negedge clk); sstart[0] = 1'b0;
    for (int c = 0; c < 20000 && nlog[0] < 51; c++) @(negedge clk);
    chk("rst_reach_50", nlog[0] === 51, nlog[0], 51);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    actl = {sbusy[0], sdone[0], serr[0], cstart[0], az[0], dang[0]};
    chk("rst_async_ctl", actl === '0, actl, 0);
    chk("rst_async_val", dval[0] === '0, dval[0], 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("rst_no_done", ndone[0] === 0, ndone[0], 0);
    chk("rst_no_restart", nlog[0] === 51, nlog[0], 51);
    sweep(0, 0, 180, 1, 1'b0, "after_reset");

`ifdef DOA_SWEEP_TIMEOUT_EN
    fill_rand(1'b0);
    hang_angle = 3;
    sweep(0, 0, 180, 1, 1'b0, "timeout");
    hang_angle = 0;
    sweep(0, 0, 180, 1, 1'b0, "timeout_first");
    hang_angle = -1;
    lat_rand   = 1'b1;
    sweep(0, 0, 180, 1, 1'b0, "err_cleared");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
